ultrasonic_echo_model: RTL and testbench
========================================

ULTRASONIC_ECHO_MODEL -- requirements
Module: ultrasonic_echo_model

Interface
REQ-001 Parameter MIN_TRIG, default 500, minimum accepted trig high width in clk cycles (10 us at 50 MHz).
REQ-002 Parameter BURST_CYC, default 10000, delay from accepted trig fall to echo rise (200 us 40 kHz burst).
REQ-003 Parameter MAX_ECHO, default 1900000, echo width for no-object and clamp value (38 ms).
REQ-004 Parameter HOLDOFF_CYC, default 500000, recovery time after echo during which trig is ignored.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 trig  input  1  asynchronous trigger from the sensor driver.
REQ-008 echo_len  input  21  programmed echo width in clk cycles (target distance); 0 = no object.
REQ-009 echo  output  1  registered echo pulse back to the driver.
REQ-010 busy  output  1  high in BURST, ECHO, HOLDOFF.
REQ-011 short_pulse  output  1  one-cycle strobe on a rejected (too short) trig.
REQ-012 meas_cnt  output  16  count of accepted triggers, wraps 0xFFFF->0.

Function
REQ-013 trig SHALL pass through a 2-flop synchronizer; trig_s is the second flop; all FSM decisions use trig_s.
REQ-014 FSM states: IDLE, TRIG_HI, BURST, ECHO, HOLDOFF.
REQ-015 IDLE: trig_s=1 -> TRIG_HI, width counter set to 1.
REQ-016 TRIG_HI: trig_s=1 -> width counter increments, saturating at MIN_TRIG; no upper width limit.
REQ-017 TRIG_HI, trig_s=0, counter>=MIN_TRIG -> BURST; latch L = (echo_len==0 or echo_len>MAX_ECHO) ? MAX_ECHO : echo_len; meas_cnt increments same edge.
REQ-018 TRIG_HI, trig_s=0, counter<MIN_TRIG -> IDLE; short_pulse=1 for exactly that one cycle.
REQ-019 BURST lasts exactly BURST_CYC cycles, then ECHO.
REQ-020 ECHO: echo=1 for exactly L cycles, then HOLDOFF; echo=1 iff state==ECHO.
REQ-021 HOLDOFF lasts exactly HOLDOFF_CYC cycles, then IDLE; if trig_s=1 at exit, go IDLE (not TRIG_HI) -- a trig must be seen low in IDLE first.
REQ-022 Timing: if trig is first sampled low at edge k after an accepted pulse, echo is high from after edge k+2+BURST_CYC through edge k+2+BURST_CYC+L.
REQ-023 trig activity in BURST, ECHO, HOLDOFF SHALL be ignored; echo_len changes after latch SHALL not affect the current pulse.
REQ-024 All counters SHALL be wide enough for their parameter with no wrap; echo_len is unsigned.

Reset
REQ-025 rst=1 at any edge SHALL force IDLE, echo=0, busy=0, short_pulse=0, meas_cnt=0, counters and synchronizer=0, including mid-echo.
REQ-026 After rst release, a trig already high SHALL be treated as a new pulse starting when trig_s first rises in IDLE.

Verification (bench overrides MIN_TRIG=5, BURST_CYC=10, MAX_ECHO=100, HOLDOFF_CYC=20)
REQ-027 trig high 5 cycles, echo_len=30 -> echo rises 12 cycles after first low sample, high exactly 30 cycles, meas_cnt=1, busy high 60 cycles.
REQ-028 trig high 4 cycles -> one short_pulse strobe, echo stays 0, meas_cnt unchanged, busy 0.
REQ-029 echo_len=0 and echo_len=150, each with valid trig -> echo width 100 cycles each.
REQ-030 second valid trig during ECHO and during HOLDOFF -> ignored, single echo; trig after HOLDOFF -> second echo, meas_cnt=2.
REQ-031 rst asserted at echo cycle 15 of 30 -> echo=0 next edge, meas_cnt=0, state IDLE; next valid trig gives full 30-cycle echo.
REQ-032 65536 valid triggers (or forced count 0xFFFF) -> meas_cnt wraps to 0.

Source files
------------

// File: rtl/ultrasonic_echo_model_if.sv
// Signal bundle between a sensor driver (master) and the echo model (slave).
// trig is a free-running level from the driver; echo/busy/short_pulse/meas_cnt are registered replies.
interface ultrasonic_echo_model_if;
    logic        trig;
    logic [20:0] echo_len;
    logic        echo;
    logic        busy;
    logic        short_pulse;
    logic [15:0] meas_cnt;
    logic [2:0]  state_dbg;

    modport master (
        output trig, echo_len,
        input  echo, busy, short_pulse, meas_cnt, state_dbg
    );

    modport slave (
        input  trig, echo_len,
        output echo, busy, short_pulse, meas_cnt, state_dbg
    );
endinterface

// File: rtl/ultrasonic_echo_model.sv
// Behavioural model of an ultrasonic ranging sensor: validates the trig pulse width,
// waits out the burst, returns an echo pulse of the programmed width, then holds off.
module ultrasonic_echo_model #(
    parameter int MIN_TRIG    = 500,
    parameter int BURST_CYC   = 10000,
    parameter int MAX_ECHO    = 1900000,
    parameter int HOLDOFF_CYC = 500000
) (
    input logic                     clk,
    input logic                     rst,
    ultrasonic_echo_model_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TRIG_HI = 3'd1,
        BURST   = 3'd2,
        ECHO    = 3'd3,
        HOLDOFF = 3'd4
    } state_t;

    localparam int MAX_A  = (MIN_TRIG > BURST_CYC) ? MIN_TRIG : BURST_CYC;
    localparam int MAX_B  = (MAX_ECHO > HOLDOFF_CYC) ? MAX_ECHO : HOLDOFF_CYC;
    localparam int MAX_P  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW_RAW = $clog2(MAX_P + 1);
    // At least as wide as echo_len so the latched length compares without truncation.
    localparam int CW     = (CW_RAW > 21) ? CW_RAW : 21;

    localparam logic [CW-1:0] ONE     = CW'(1);
    localparam logic [CW-1:0] MIN_C   = CW'(MIN_TRIG);
    localparam logic [CW-1:0] BURST_C = CW'(BURST_CYC);
    localparam logic [CW-1:0] HOLD_C  = CW'(HOLDOFF_CYC);
    localparam logic [20:0]   MAX_L   = 21'(MAX_ECHO);

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [20:0]    len_q, len_d;
    logic           sync1_q, sync1_d;
    logic           trig_s_q, trig_s_d;
    logic           armed_q, armed_d;
    logic           echo_q, echo_d;
    logic           busy_q, busy_d;
    logic           short_q, short_d;
    logic [15:0]    meas_cnt_q, meas_cnt_d;

    always_comb begin
        sync1_d    = bus.trig;
        trig_s_d   = sync1_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        armed_d    = 1'b0;
        short_d    = 1'b0;
        meas_cnt_d = meas_cnt_q;

        case (state_q)
            // armed only after trig_s has been seen low while idle, so a level
            // still high on leaving HOLDOFF cannot start a measurement
            IDLE: begin
                if (trig_s_q && armed_q) begin
                    state_d = TRIG_HI;
                    cnt_d   = ONE;
                end else begin
                    armed_d = !trig_s_q;
                end
            end
            TRIG_HI: begin
                if (trig_s_q) begin
                    if (cnt_q < MIN_C) cnt_d = cnt_q + ONE;
                end else if (cnt_q >= MIN_C) begin
                    state_d    = BURST;
                    cnt_d      = ONE;
                    len_d      = (bus.echo_len == 21'd0 || bus.echo_len > MAX_L) ? MAX_L : bus.echo_len;
                    meas_cnt_d = meas_cnt_q + 16'd1;
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    short_d = 1'b1;
                end
            end
            BURST: begin
                if (cnt_q == BURST_C) begin
                    state_d = ECHO;
                    cnt_d   = ONE;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            ECHO: begin
                if (cnt_q == CW'(len_q)) begin
                    state_d = HOLDOFF;
                    cnt_d   = ONE;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            HOLDOFF: begin
                if (cnt_q == HOLD_C) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        echo_d = (state_d == ECHO);
        busy_d = (state_d == BURST) || (state_d == ECHO) || (state_d == HOLDOFF);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            sync1_q    <= 1'b0;
            trig_s_q   <= 1'b0;
            armed_q    <= 1'b0;
            echo_q     <= 1'b0;
            busy_q     <= 1'b0;
            short_q    <= 1'b0;
            meas_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            sync1_q    <= sync1_d;
            trig_s_q   <= trig_s_d;
            armed_q    <= armed_d;
            echo_q     <= echo_d;
            busy_q     <= busy_d;
            short_q    <= short_d;
            meas_cnt_q <= meas_cnt_d;
        end
    end

    assign bus.echo        = echo_q;
    assign bus.busy        = busy_q;
    assign bus.short_pulse = short_q;
    assign bus.meas_cnt    = meas_cnt_q;
    assign bus.state_dbg   = state_q;
endmodule

// File: tb/tb_ultrasonic_echo_model.sv
// Directed bench for ultrasonic_echo_model: expected echo widths and rise cycles are
// queued when a trigger is driven and checked when the echo pulse falls.
module tb_ultrasonic_echo_model;
    localparam int MIN_TRIG    = 5;
    localparam int BURST_CYC   = 10;
    localparam int MAX_ECHO    = 100;
    localparam int HOLDOFF_CYC = 20;

    logic clk = 1'b0;
    logic rst;

    ultrasonic_echo_model_if bus();

    ultrasonic_echo_model #(
        .MIN_TRIG(MIN_TRIG),
        .BURST_CYC(BURST_CYC),
        .MAX_ECHO(MAX_ECHO),
        .HOLDOFF_CYC(HOLDOFF_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic [31:0] exp_q[$];
    logic [31:0] rise_q[$];

    logic echo_prev = 1'b0;
    logic busy_prev = 1'b0;
    logic drop_pending = 1'b0;
    int   rise_cyc = 0;
    int   busy_run = 0;
    int   last_busy_len = 0;
    int   short_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_width(input logic [20:0] len);
        logic [31:0] l32;
        l32 = 32'(len);
        if (l32 == 32'd0 || l32 > 32'(MAX_ECHO)) return 32'(MAX_ECHO);
        return l32;
    endfunction

    // Echo pulse monitor: pops the scoreboard on every falling edge of echo.
    always @(negedge clk) begin
        if (bus.echo && !echo_prev) rise_cyc = cyc;
        if (!bus.echo && echo_prev) begin
            if (drop_pending) begin
                drop_pending = 1'b0;
            end else if (exp_q.size() == 0) begin
                check("echo_unexpected_width", 32'(cyc - rise_cyc), 32'd0);
            end else begin
                check("echo_width", 32'(cyc - rise_cyc), exp_q.pop_front());
                check("echo_rise_cycle", 32'(rise_cyc), rise_q.pop_front());
            end
        end
        if (bus.busy) begin
            busy_run++;
        end else if (busy_prev) begin
            last_busy_len = busy_run;
            busy_run = 0;
        end
        if (bus.short_pulse) short_cnt++;
        echo_prev = bus.echo;
        busy_prev = bus.busy;
    end

    task automatic send_trig(input int w, input logic [20:0] len, input bit exp_echo);
        @(negedge clk);
        bus.trig = 1'b1;
        bus.echo_len = len;
        repeat (w) @(negedge clk);
        bus.trig = 1'b0;
        if (exp_echo) begin
            exp_q.push_back(exp_width(len));
            rise_q.push_back(32'(cyc + 1 + 2 + BURST_CYC));
        end
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.busy) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(n < 2000), 32'd1);
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int s0;
        int n;
        bit busy_seen;
        bit echo_seen;

        bus.trig = 1'b0;
        bus.echo_len = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_echo", 32'(bus.echo), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_short", 32'(bus.short_pulse), 32'd0);
        check("rst_meas", 32'(bus.meas_cnt), 32'd0);
        check("rst_state", 32'(bus.state_dbg), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // minimum-width trig, 30-cycle echo, 60 busy cycles
        send_trig(5, 21'd30, 1'b1);
        wait_done("t1_timeout");
        check("t1_meas", 32'(bus.meas_cnt), 32'd1);
        check("t1_busy_len", 32'(last_busy_len), 32'(BURST_CYC + 30 + HOLDOFF_CYC));

        // one cycle too short: strobe only
        s0 = short_cnt;
        busy_seen = 1'b0;
        echo_seen = 1'b0;
        send_trig(4, 21'd30, 1'b0);
        repeat (30) begin
            @(negedge clk);
            if (bus.busy) busy_seen = 1'b1;
            if (bus.echo) echo_seen = 1'b1;
        end
        check("t2_short_cycles", 32'(short_cnt - s0), 32'd1);
        check("t2_busy_seen", 32'(busy_seen), 32'd0);
        check("t2_echo_seen", 32'(echo_seen), 32'd0);
        check("t2_meas", 32'(bus.meas_cnt), 32'd1);

        // clamp boundaries: 0 and >MAX clamp, MAX and 1 pass through
        send_trig(6, 21'd0, 1'b1);
        wait_done("t3a_timeout");
        send_trig(8, 21'd150, 1'b1);
        wait_done("t3b_timeout");
        send_trig(5, 21'd100, 1'b1);
        wait_done("t3c_timeout");
        send_trig(5, 21'd1, 1'b1);
        wait_done("t3d_timeout");
        check("t3_meas", 32'(bus.meas_cnt), 32'd5);

        // reset at echo cycle 15 of 30
        send_trig(5, 21'd30, 1'b1);
        n = 0;
        while (!bus.echo && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t4_rise_timeout", 32'(n < 100), 32'd1);
        repeat (14) @(negedge clk);
        check("t4_echo_mid", 32'(bus.echo), 32'd1);
        rst = 1'b1;
        exp_q.delete();
        rise_q.delete();
        drop_pending = 1'b1;
        @(negedge clk);
        check("t4_echo_after_rst", 32'(bus.echo), 32'd0);
        check("t4_busy_after_rst", 32'(bus.busy), 32'd0);
        check("t4_meas_after_rst", 32'(bus.meas_cnt), 32'd0);
        check("t4_state_after_rst", 32'(bus.state_dbg), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        send_trig(5, 21'd30, 1'b1);
        wait_done("t4_timeout");
        check("t4_meas", 32'(bus.meas_cnt), 32'd1);

        // trig already high when reset releases counts as a fresh pulse
        @(negedge clk);
        bus.trig = 1'b1;
        bus.echo_len = 21'd20;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        bus.trig = 1'b0;
        exp_q.push_back(32'd20);
        rise_q.push_back(32'(cyc + 1 + 2 + BURST_CYC));
        wait_done("t5_timeout");
        check("t5_meas", 32'(bus.meas_cnt), 32'd1);

        // triggers in ECHO, HOLDOFF and straddling HOLDOFF exit are ignored
        pulse_reset();
        s0 = short_cnt;
        send_trig(5, 21'd30, 1'b1);
        repeat (20) @(negedge clk);
        check("t6_in_echo", 32'(bus.state_dbg), 32'd3);
        send_trig(6, 21'd7, 1'b0);
        repeat (20) @(negedge clk);
        check("t6_in_holdoff", 32'(bus.state_dbg), 32'd4);
        send_trig(6, 21'd7, 1'b0);
        send_trig(15, 21'd7, 1'b0);
        wait_done("t6a_timeout");
        repeat (5) @(negedge clk);
        check("t6_meas_ignored", 32'(bus.meas_cnt), 32'd1);
        check("t6_short_ignored", 32'(short_cnt - s0), 32'd0);
        check("t6_idle", 32'(bus.state_dbg), 32'd0);
        send_trig(5, 21'd30, 1'b1);
        wait_done("t6b_timeout");
        check("t6_meas", 32'(bus.meas_cnt), 32'd2);

        // meas_cnt wraps 0xFFFF -> 0
        @(negedge clk);
        force dut.meas_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.meas_cnt_q;
        @(negedge clk);
        check("t7_meas_preset", 32'(bus.meas_cnt), 32'hFFFF);
        send_trig(5, 21'd10, 1'b1);
        wait_done("t7_timeout");
        check("t7_meas_wrap", 32'(bus.meas_cnt), 32'd0);

        check("sb_leftover", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
